// File: rtl/ring_fifo_arb_pkg.sv
// ring_fifo_arb_pkg: arbiter state encoding and wrapping pointer helper.
package ring_fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    function automatic int wrap_inc(input int p, input int n);
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/ring_fifo_wr_arbiter_if.sv
// ring_fifo_wr_arbiter_if: producer request bus plus FIFO write port of the arbiter.
interface ring_fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] data;
    logic [N_REQ-1:0]            ack;
    logic                        fifo_write;
    logic [DATA_WIDTH-1:0]       fifo_datain;
    logic                        fifo_full;
    logic [$clog2(N_REQ)-1:0]    grant_id;
    logic                        busy;

    modport master (
        output req, data, fifo_full,
        input  ack, fifo_write, fifo_datain, grant_id, busy
    );

    modport slave (
        input  req, data, fifo_full,
        output ack, fifo_write, fifo_datain, grant_id, busy
    );
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or after rr_ptr, wrapping at N_REQ-1.
module rr_priority_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);
    localparam int IW = $clog2(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;

    // rotate so bit 0 is rr_ptr, then the lowest set bit is the offset
    always_comb begin
        dbl = {req, req} >> rr_ptr;
        rot = dbl[N_REQ-1:0];
        found = 1'b0;
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off = IW'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        idx = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
    end
endmodule

// File: rtl/ring_fifo_wr_arbiter.sv
// ring_fifo_wr_arbiter: round-robin burst arbiter sharing one ring FIFO write port.
module ring_fifo_wr_arbiter
    import ring_fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic                  clk,
    input logic                  reset,
    ring_fifo_wr_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr, rr_nx, owner, owner_nx, idx;
    logic [CW-1:0]   beat_cnt, cnt_nx;
    logic [N_REQ-1:0] ack_c;
    logic [DATA_WIDTH-1:0] din;
    logic            found;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req),
        .rr_ptr(rr_ptr),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_nx;
            owner    <= owner_nx;
            beat_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        cnt_nx   = beat_cnt;
        ack_c    = '0;
        if (state == IDLE) begin
            if (!bus.fifo_full && found) begin
                ack_c[idx] = 1'b1;
                owner_nx   = idx;
                cnt_nx     = CW'(1);
                if (MAX_BURST == 1) rr_nx = IW'(wrap_inc(int'(idx), N_REQ));
                else state_nx = BURST;
            end
        end else if (!bus.req[owner]) begin
            state_nx = IDLE;
            rr_nx    = IW'(wrap_inc(int'(owner), N_REQ));
        end else if (!bus.fifo_full) begin
            ack_c[owner] = 1'b1;
            cnt_nx       = beat_cnt + CW'(1);
            if (cnt_nx == CW'(MAX_BURST)) begin
                state_nx = IDLE;
                rr_nx    = IW'(wrap_inc(int'(owner), N_REQ));
            end
        end
    end

    // at most one ack bit is set, so OR-ing slices is a clean mux
    always_comb begin
        din = '0;
        for (int i = 0; i < N_REQ; i++)
            if (ack_c[i]) din = din | bus.data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        bus.ack         = reset ? ack_c : '0;
        bus.fifo_write  = reset && |ack_c;
        bus.fifo_datain = reset ? din : '0;
        bus.busy        = reset && state == BURST;
        bus.grant_id    = (reset && state == BURST) ? owner : '0;
    end
endmodule
